// File: rtl/monty_pkg.sv
// Shared types, default sizes and helpers for the word-serial Montgomery
// reduction controller.
package monty_pkg;

    localparam int K       = 128;   // product width
    localparam int Q_LEN   = 64;    // modulus width
    localparam int R       = 38;    // datapath word size, q = qH*2^R + 1
    localparam int ITER    = 2;     // reduction passes
    localparam int RED_LAT = 5;     // datapath latency in cycles

    localparam int PASS_W  = $clog2(ITER + 1);
    localparam int LAT_W   = $clog2(RED_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        SUB,
        DONE
    } monty_st_t;

    // q = qH*2^R + 1, built at Q_LEN+1 bits so later compares never wrap.
    function automatic logic [Q_LEN:0] monty_q(input logic [Q_LEN-R-1:0] qh);
        return {1'b0, qh, {R{1'b0}}} + {{Q_LEN{1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/monty_final_sub.sv
// Final conditional subtraction of the Montgomery result and detection of
// inputs that broke the C < q*2^(ITER*R) precondition.
module monty_final_sub
    import monty_pkg::*;
(
    input  logic [K-1:0]       acc,
    input  logic [Q_LEN-R-1:0] qh,
    output logic [Q_LEN-1:0]   res,
    output logic               ovf
);

    logic [Q_LEN:0]   v;
    logic [Q_LEN:0]   q;
    logic [Q_LEN+1:0] q2;

    // Single compare/subtract against q plus the 2q overflow test.
    always_comb begin
        // NOTE: every output is assigned on every path through this block, so no latch is inferred.
        v   = acc[Q_LEN:0];
        q   = monty_q(qh);
        q2  = {q, 1'b0};
        res = v[Q_LEN-1:0];
        if (v >= q) begin
            res = Q_LEN'(v - q);
        end
        ovf = (|acc[K-1:Q_LEN+1]) | ({1'b0, v} >= q2);
    end

endmodule

// File: rtl/monty_red_ctrl.sv
// Sequencer that loops one product through the word_red_38 datapath ITER
// times, then applies the final subtraction and holds the result until the
// consumer takes it.
module monty_red_ctrl
    import monty_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [K-1:0]       in_C,
    input  logic [Q_LEN-R-1:0] in_qH,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Q_LEN-1:0]   out_res,
    output logic               out_ovf,
    output logic [K-1:0]       red_C,
    output logic [Q_LEN-R-1:0] red_qH,
    input  logic [K-R-1:0]     red_T
);

    monty_st_t          state;
    logic [K-1:0]       acc;
    logic [Q_LEN-R-1:0] qh_r;
    logic [PASS_W-1:0]  pass;
    logic [LAT_W-1:0]   lat;

    logic [Q_LEN-1:0]   sub_res;
    logic               sub_ovf;

    // qH is latched once per transaction and stays constant on the datapath.
    assign red_qH = qh_r;

    monty_final_sub u_final_sub (
        .acc (acc),
        .qh  (qh_r),
        .res (sub_res),
        .ovf (sub_ovf)
    );

    // Transaction FSM with registered handshake, datapath and result outputs.
    always_ff @(posedge clk) begin
        // NOTE: state and every registered output use <= so all branches read the values from before this edge.
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            qh_r      <= '0;
            pass      <= '0;
            lat       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_res   <= '0;
            out_ovf   <= 1'b0;
            red_C     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_ready && in_valid) begin
                        acc      <= in_C;
                        qh_r     <= in_qH;
                        pass     <= '0;
                        in_ready <= 1'b0;
                        state    <= ISSUE;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    red_C <= acc;
                    lat   <= LAT_W'(RED_LAT - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (lat == '0) begin
                        // Only this capture point consumes red_T, so stale
                        // datapath results after an abort are never used.
                        acc  <= K'(red_T);
                        pass <= pass + 1'b1;
                        if (pass == PASS_W'(ITER - 1)) begin
                            state <= SUB;
                        end else begin
                            state <= ISSUE;
                        end
                    end else begin
                        lat <= lat - 1'b1;
                    end
                end
                SUB: begin
                    out_res   <= sub_res;
                    out_ovf   <= sub_ovf;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_monty_red_ctrl.sv
// Self-checking bench for monty_red_ctrl: a behavioural word reduction
// datapath, a scoreboard fed at accept time and a monitor that checks every
// delivered result against C*2^(-ITER*R) mod q.
`timescale 1ns/1ps
module tb_monty_red_ctrl;
    import monty_pkg::*;

    localparam int TW      = K - R;
    localparam int WIDE    = 192;
    localparam int PIPE    = RED_LAT - 1;
    localparam int LATENCY = ITER * (RED_LAT + 1) + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [K-1:0]       in_C = '0;
    logic [Q_LEN-R-1:0] in_qH = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [Q_LEN-1:0]   out_res;
    logic               out_ovf;
    logic [K-1:0]       red_C;
    logic [Q_LEN-R-1:0] red_qH;
    logic [TW-1:0]      red_T;

    monty_red_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_C      (in_C),
        .in_qH     (in_qH),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_ovf   (out_ovf),
        .red_C     (red_C),
        .red_qH    (red_qH),
        .red_T     (red_T)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [Q_LEN-1:0] res;
        logic             ovf;
        int unsigned      acc_cyc;
    } exp_t;
    exp_t exp_q[$];

    bit rand_rdy = 1'b0;

    task automatic check(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One word reduction step: T = (C + m*q) / 2^R with m = -C mod 2^R.
    function automatic logic [TW-1:0] dp_reduce(input logic [K-1:0] c, input logic [Q_LEN-R-1:0] qh);
        logic [WIDE-1:0] q;
        logic [R-1:0]    lo;
        logic [R-1:0]    m;
        logic [WIDE-1:0] s;
        q  = (WIDE'(qh) << R) + WIDE'(1);
        lo = c[R-1:0];
        m  = R'(0) - lo;
        s  = WIDE'(c) + WIDE'(m) * q;
        return TW'(s >> R);
    endfunction

    // Reference: x = C mod q, then divide by 2 modulo q ITER*R times.
    function automatic logic [Q_LEN-1:0] ref_mont(input logic [K-1:0] c, input logic [Q_LEN-R-1:0] qh);
        logic [WIDE-1:0] q;
        logic [WIDE-1:0] x;
        q = (WIDE'(qh) << R) + WIDE'(1);
        x = WIDE'(c) % q;
        for (int i = 0; i < ITER * R; i++) begin
            x = x[0] ? ((x + q) >> 1) : (x >> 1);
        end
        return Q_LEN'(x);
    endfunction

    // Datapath stand-in: register stages so red_T reflects red_C by the
    // controller's capture edge RED_LAT cycles after red_C is driven.
    logic [TW-1:0] pipe [PIPE];
    initial for (int i = 0; i < PIPE; i++) pipe[i] = '0;
    always @(posedge clk) begin
        pipe[0] <= dp_reduce(red_C, red_qH);
        for (int i = 1; i < PIPE; i++) pipe[i] <= pipe[i-1];
    end
    assign red_T = pipe[PIPE-1];

    // Random consumer backpressure during the bulk phase.
    always @(negedge clk) begin
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: latency on each rising out_valid, data at each handshake.
    initial begin : monitor
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (out_valid && !prev) begin
                    if (exp_q.size() == 0) begin
                        check("out_valid_without_request", K'(out_valid), K'(0));
                    end else begin
                        check("latency", K'(cyc - exp_q[0].acc_cyc), K'(LATENCY));
                    end
                end
                if (out_valid && out_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_res", K'(out_res), K'(e.res));
                    check("out_ovf", K'(out_ovf), K'(e.ovf));
                end
                prev = out_valid;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [K-1:0] c, input logic [Q_LEN-R-1:0] qh,
                        input logic [Q_LEN-1:0] r, input logic o);
        int   n;
        exp_t e;
        n        = 0;
        in_C     = c;
        in_qH    = qh;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", K'(in_ready), K'(1));
            in_valid = 1'b0;
            return;
        end
        e.res     = r;
        e.ovf     = o;
        e.acc_cyc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", K'(exp_q.size()), K'(0));
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready",  K'(in_ready),  K'(0));
        check("rst_out_valid", K'(out_valid), K'(0));
        check("rst_out_res",   K'(out_res),   K'(0));
        check("rst_out_ovf",   K'(out_ovf),   K'(0));
        check("rst_red_C",     red_C,         K'(0));
        check("rst_red_qH",    K'(red_qH),    K'(0));
    endtask

    function automatic logic [K-1:0] rand_c();
        logic [K-1:0] c;
        c = {$urandom(), $urandom(), $urandom(), $urandom()};
        // Keep the first-pass value within red_T's width.
        c[K-1] = 1'b0;
        return c;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [K-1:0]       c;
        logic [Q_LEN-R-1:0] qh_big;
        logic [Q_LEN-1:0]   held;
        int                 n;

        qh_big = {(Q_LEN-R){1'b1}};

        // Power-on reset.
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs();
        end
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", K'(in_ready), K'(1));

        // Directed values with q = 2^38 + 1.
        c = K'(1) << 76;
        send(c, (Q_LEN-R)'(1), Q_LEN'(1), 1'b0);
        drain();
        c = K'(1) << 114;
        send(c, (Q_LEN-R)'(1), Q_LEN'(1) << 38, 1'b0);
        drain();
        c = (K'(1) << 38) + K'(1);
        send(c, (Q_LEN-R)'(1), Q_LEN'(0), 1'b0);
        drain();

        // Reset while the controller waits on the datapath.
        c = rand_c();
        send(c, qh_big, ref_mont(c, qh_big), 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs();
        end
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_abort", K'(in_ready), K'(1));
        repeat (20) @(negedge clk);
        check("aborted_out_valid", K'(out_valid), K'(0));

        // Bulk random traffic with random consumer stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            c = rand_c();
            send(c, qh_big, ref_mont(c, qh_big), 1'b0);
        end
        drain();
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        // Held result under backpressure.
        out_ready = 1'b0;
        c = rand_c();
        send(c, qh_big, ref_mont(c, qh_big), 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_rise", K'(out_valid), K'(1));
        held     = out_res;
        in_C     = rand_c();
        in_qH    = qh_big;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_out_res_stable", K'(out_res), K'(held));
            check("bp_out_valid_held", K'(out_valid), K'(1));
            check("bp_in_ready_low", K'(in_ready), K'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("idle_after_release", K'(in_ready), K'(1));
        check("out_valid_after_release", K'(out_valid), K'(0));
        drain();

        // Precondition violation: result still single-subtracted, ovf set.
        c = K'(1) << 127;
        send(c, (Q_LEN-R)'(1), (Q_LEN'(1) << 51) - ((Q_LEN'(1) << 38) + Q_LEN'(1)), 1'b1);
        drain();

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
